// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings, rounding-mode codes,
// divider FSM states and exception-flag bit positions.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int FL_INV = 3;
  localparam int FL_DBZ = 2;
  localparam int FL_OVF = 1;
  localparam int FL_UNF = 0;

endpackage

// File: rtl/fp_div_mant_iter.sv
// Radix-2 restoring significand divider: one quotient bit per cycle for QBITS
// cycles; the dividend must already be normalised into [divisor, 2*divisor).
module fp_div_mant_iter #(
  parameter int QBITS = 26,
  parameter int SW    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [SW:0]      dividend_i,
  input  logic [SW-1:0]    divisor_i,
  output logic [QBITS-1:0] quo_o,
  output logic             rem_nz_o,
  output logic             done_o
);
  localparam int CW = $clog2(QBITS);

  logic [SW:0]      rem_q;
  logic [SW-1:0]    div_q;
  logic [QBITS-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [SW+1:0]    diff;

  assign diff = {1'b0, rem_q} - {2'b00, div_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= dividend_i;
      div_q <= divisor_i;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      // A kept difference is below the divisor, so the shift never loses a bit.
      if (!diff[SW+1]) begin
        rem_q <= {diff[SW-1:0], 1'b0};
        quo_q <= {quo_q[QBITS-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[SW-1:0], 1'b0};
        quo_q <= {quo_q[QBITS-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(QBITS - 1)) run_q <= 1'b0;
    end
  end

  assign quo_o    = quo_q;
  assign rem_nz_o = |rem_q;
  assign done_o   = run_q && (cnt_q == CW'(QBITS - 1));

endmodule

// File: rtl/fp_div_iter.sv
// Fixed-latency binary32 divider: unpack/classify, iterative significand
// division, rounding with overflow/underflow handling, one-cycle done pulse.
module fp_div_iter
  import fp32_pkg::*;
#(
  parameter int QBITS = 26,
  parameter bit FTZ   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] flout_a,
  input  logic [31:0] flout_b,
  input  logic [1:0]  round_cfg,
  output logic [31:0] flout_c,
  output logic        done,
  output logic        busy,
  output logic [3:0]  flags
);
  localparam int SW = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_OVF  = EW'(255);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  state_e state_q, state_d;
  logic [31:0]            a_q, b_q;
  logic [1:0]             rm_q;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;
  logic                   spec_q;
  logic [31:0]            spec_res_q;
  logic [3:0]             spec_fl_q;
  logic [31:0]            c_q, c_d;
  logic [3:0]             fl_q, fl_d;

  function automatic logic round_up(input logic [1:0] rm, input logic sgn,
                                    input logic l, input logic g,
                                    input logic r, input logic s);
    case (rm)
      RM_RNE:  round_up = g & (r | s | l);
      RM_RZ:   round_up = 1'b0;
      RM_RUP:  round_up = (g | r | s) & ~sgn;
      default: round_up = (g | r | s) & sgn;
    endcase
  endfunction

  function automatic logic rounds_away(input logic [1:0] rm, input logic sgn);
    rounds_away = (rm == RM_RNE) || (rm == RM_RUP && !sgn) || (rm == RM_RDN && sgn);
  endfunction

  // ---- unpack / classify (operates on the operands latched at accept)
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_d, lt;
  logic [SW-1:0]    ma, mb;
  logic [SW:0]      dvd;
  logic [EW-1:0]    exp_u;
  logic             spec_d;
  logic [31:0]      spec_res_d;
  logic [3:0]       spec_fl_d;

  assign ea     = a_q[MAN_W +: EXP_W];
  assign eb     = b_q[MAN_W +: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = !(|ea) && (FTZ || !(|fa));
  assign b_zero = !(|eb) && (FTZ || !(|fb));
  assign sign_d = a_q[31] ^ b_q[31];
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign lt     = ma < mb;
  assign dvd    = lt ? {ma, 1'b0} : {1'b0, ma};
  assign exp_u  = {2'b00, ea} - {2'b00, eb} + EW'(BIAS) - {{(EW-1){1'b0}}, lt};

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = '0;
    spec_fl_d  = '0;
    if (a_nan || b_nan) begin
      spec_res_d = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_d        = QNAN;
      spec_fl_d[FL_INV] = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_res_d        = {sign_d, POS_INF[30:0]};
      spec_fl_d[FL_DBZ] = 1'b1;
    end else if (a_inf) begin
      spec_res_d = {sign_d, POS_INF[30:0]};
    end else if (a_zero || b_inf) begin
      spec_res_d = {sign_d, 31'h0};
    end else begin
      spec_d = 1'b0;
    end
  end

  // ---- significand division
  logic [QBITS-1:0] quo;
  logic             rem_nz, core_done;

  fp_div_mant_iter #(.QBITS(QBITS), .SW(SW)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start_i   (state_q == S_UNPACK),
    .dividend_i(dvd),
    .divisor_i (mb),
    .quo_o     (quo),
    .rem_nz_o  (rem_nz),
    .done_o    (core_done)
  );

  // ---- round / pack
  logic [SW-1:0]        sig;
  logic                 up;
  logic [SW:0]          sum;
  logic [MAN_W-1:0]     man;
  logic signed [EW-1:0] exp_r;

  assign sig   = quo[QBITS-1 -: SW];
  assign up    = round_up(rm_q, sign_q, sig[0], quo[QBITS-SW-1], quo[QBITS-SW-2], rem_nz);
  assign sum   = {1'b0, sig} + {{SW{1'b0}}, up};
  assign man   = sum[SW] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign exp_r = exp_q + $signed({{(EW-1){1'b0}}, sum[SW]});

  always_comb begin
    c_d  = {sign_q, exp_r[EXP_W-1:0], man};
    fl_d = '0;
    if (spec_q) begin
      c_d  = spec_res_q;
      fl_d = spec_fl_q;
    end else if (exp_r >= EXP_OVF) begin
      c_d          = rounds_away(rm_q, sign_q) ? {sign_q, POS_INF[30:0]} : {sign_q, MAX_FIN[30:0]};
      fl_d[FL_OVF] = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      c_d          = {sign_q, 31'h0};
      fl_d[FL_UNF] = 1'b1;
    end
  end

  // ---- control
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_UNPACK;
      S_UNPACK: state_d = S_DIV;
      S_DIV:    if (core_done) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rm_q       <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_fl_q  <= '0;
      c_q        <= '0;
      fl_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && en) begin
        a_q  <= flout_a;
        b_q  <= flout_b;
        rm_q <= round_cfg;
      end
      if (state_q == S_UNPACK) begin
        sign_q     <= sign_d;
        exp_q      <= $signed(exp_u);
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
        spec_fl_q  <= spec_fl_d;
      end
      if (state_q == S_ROUND) begin
        c_q  <= c_d;
        fl_q <= fl_d;
      end
    end
  end

  assign flout_c = c_q;
  assign flags   = fl_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: directed corner cases, control scenarios
// and randomized operands checked against an exact-arithmetic reference model.
module tb_fp_div_iter;

  localparam int LAT = 29;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] flout_a, flout_b;
  logic [1:0]  round_cfg;
  logic [31:0] flout_c;
  logic        done, busy;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] c;
    logic [3:0]  f;
    int          acc;
  } exp_t;
  exp_t sb_q[$];

  fp_div_iter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flout_a  (flout_a),
    .flout_b  (flout_b),
    .round_cfg(round_cfg),
    .flout_c  (flout_c),
    .done     (done),
    .busy     (busy),
    .flags    (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Exact quotient with 40 fractional bits of headroom plus the true remainder.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] rm);
    bit s, an, bn, ai, bi, az, bz, up, inexact, away;
    int ea, eb, e, sh;
    longint unsigned ma, mb, num, q, sig, rest, half;
    bit remz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn) return {4'b0000, 32'h7FC0_0000};
    if ((az && bz) || (ai && bi)) return {4'b1000, 32'h7FC0_0000};
    if (bz && !ai) return {4'b0100, s, 8'hFF, 23'h0};
    if (ai) return {4'b0000, s, 8'hFF, 23'h0};
    if (az || bi) return {4'b0000, s, 31'h0};
    ma   = 64'(a[22:0]) | (64'd1 << 23);
    mb   = 64'(b[22:0]) | (64'd1 << 23);
    num  = ma << 40;
    q    = num / mb;
    remz = (num % mb) == 0;
    e    = ea - eb + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    sig     = q >> sh;
    rest    = q & ((64'd1 << sh) - 1);
    half    = 64'd1 << (sh - 1);
    inexact = (rest != 0) || !remz;
    case (rm)
      2'b00:   up = (rest > half) || (rest == half && (!remz || sig[0]));
      2'b01:   up = 1'b0;
      2'b10:   up = inexact && !s;
      default: up = inexact && s;
    endcase
    sig = sig + 64'(up);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e   = e + 1;
    end
    if (e >= 255) begin
      away = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
      return away ? {4'b0010, s, 8'hFF, 23'h0} : {4'b0010, s, 8'hFE, 23'h7F_FFFF};
    end
    if (e <= 0) return {4'b0001, s, 31'h0};
    return {4'b0000, s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    logic [31:0] sp[7] = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                           32'h7FC0_0000, 32'h0000_0001, 32'h3F80_0000};
    int e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: ;
      1: v = sp[$urandom_range(0, 6)];
      2: begin
        e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : int'($urandom_range(245, 254));
        v[30:23] = 8'(e);
      end
      3: begin
        v[30:23] = 8'(127 + int'($urandom_range(0, 8)) - 4);
        v[22:0]  = v[22:0] & 23'h7F_0000;
      end
      default: v[30:23] = 8'(127 + int'($urandom_range(0, 40)) - 20);
    endcase
    return v;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic [31:0] ec, input logic [3:0] ef, input int hold);
    exp_t x;
    wait_idle();
    flout_a   = a;
    flout_b   = b;
    round_cfg = rm;
    en        = 1'b1;
    x.c   = ec;
    x.f   = ef;
    x.acc = cyc + 1;
    sb_q.push_back(x);
    @(negedge clk);
    chk("busy_after_accept", 64'(busy), 64'd1);
    repeat (hold - 1) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    logic [35:0] r;
    r = model(a, b, rm);
    issue(a, b, rm, r[31:0], r[35:32], 1);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done flout_c=%h flags=%b, no operation outstanding", flout_c, flags);
      end else begin
        x = sb_q.pop_front();
        chk("result", 64'(flout_c), 64'(x.c));
        chk("flags", 64'(flags), 64'(x.f));
        chk("latency", 64'(cyc - x.acc + 1), 64'(LAT));
        chk("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    flout_a   = '0;
    flout_b   = '0;
    round_cfg = '0;
    repeat (2) @(negedge clk);
    chk("reset_flout_c", 64'(flout_c), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(32'h40C0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 4'b0000, 1);
    issue(32'h3F80_0000, 32'h4040_0000, 2'b00, 32'h3EAA_AAAB, 4'b0000, 1);
    issue(32'h3F80_0000, 32'h4040_0000, 2'b01, 32'h3EAA_AAAA, 4'b0000, 1);
    issue(32'hBF80_0000, 32'h4040_0000, 2'b11, 32'hBEAA_AAAB, 4'b0000, 1);
    issue(32'h3F80_0000, 32'h0000_0000, 2'b00, 32'h7F80_0000, 4'b0100, 1);
    issue(32'h0000_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000, 4'b1000, 1);
    issue(32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 4'b0000, 1);
    issue(32'h7F7F_FFFF, 32'h3F00_0000, 2'b00, 32'h7F80_0000, 4'b0010, 1);
    issue(32'h7F7F_FFFF, 32'h3F00_0000, 2'b01, 32'h7F7F_FFFF, 4'b0010, 1);
    issue(32'h0080_0000, 32'h4000_0000, 2'b00, 32'h0000_0000, 4'b0001, 1);
    issue(32'h8080_0000, 32'h4000_0000, 2'b00, 32'h8000_0000, 4'b0001, 1);

    // en held for the accept edge plus five more: exactly one operation.
    issue(32'h40C0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 4'b0000, 6);

    // Reset mid-operation aborts: no done, outputs cleared.
    wait_idle();
    flout_a   = 32'h3F80_0000;
    flout_b   = 32'h4040_0000;
    round_cfg = 2'b00;
    en        = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_flout_c", 64'(flout_c), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'h3F80_0000, 32'h4040_0000, 2'b00, 32'h3EAA_AAAB, 4'b0000, 1);

    for (int i = 0; i < 200; i++) begin
      issue_model(rand_fp(), rand_fp(), 2'($urandom_range(0, 3)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
